// File: rtl/dmac_write_burst_gen.sv
// dmac_write_burst_gen
//   Splits one channel write command (dst/src address, byte count) into AXI
//   INCR burst requests for the write initiator. It counts the bursts that
//   have no B response yet and reports command completion and error once
//   every response has returned.
//
//   Optional feature macro: DMAC_WR_4K_SPLIT_EN. When it is defined, bursts
//   never cross a 4 KB boundary. When it is undefined, burst size is limited
//   only by MAX_BURST_LEN and the beats remaining.
//
//   Ports
//     clk, rst_n          clock, async active-low reset
//     cmd_*               command in (valid/ready), done pulse + error out
//     wr_req_*            registered burst request (valid/ready)
//     m_axi_b*            AXI write response channel (bready constant 1)
module dmac_write_burst_gen #(
  parameter int ADDR_WD         = 32,
  parameter int DATA_WD         = 32,
  parameter int LEN_WD          = 32,
  parameter int MAX_BURST_LEN   = 16,
  parameter int MAX_OUTSTANDING = 8,
  localparam int BYTES  = DATA_WD / 8,
  localparam int OFS_WD = $clog2(BYTES),
  localparam int CNT_WD = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [ADDR_WD-1:0] cmd_dst_addr,
  input  logic [ADDR_WD-1:0] cmd_src_addr,
  input  logic [LEN_WD-1:0]  cmd_bytes,
  output logic               cmd_done,
  output logic               cmd_err,
  output logic               wr_req_valid,
  input  logic               wr_req_ready,
  output logic [ADDR_WD-1:0] wr_req_addr,
  output logic [1:0]         wr_req_burst,
  output logic [7:0]         wr_req_len,
  output logic [OFS_WD-1:0]  wr_req_data_offset,
  output logic [2:0]         wr_req_size,
  output logic               wr_req_last,
  input  logic               m_axi_bvalid,
  output logic               m_axi_bready,
  input  logic [1:0]         m_axi_bresp
);

  localparam int REM_WD = LEN_WD + 1;
`ifdef DMAC_WR_4K_SPLIT_EN
  localparam bit SPLIT_4K = 1'b1;
`else
  localparam bit SPLIT_4K = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_e;

  state_e              state_q, state_d;
  logic [REM_WD-1:0]   rem_q, rem_d;
  logic [ADDR_WD-1:0]  addr_q, addr_d;
  logic [7:0]          len_q, len_d;
  logic                last_q, last_d;
  logic                valid_q, valid_d;
  logic [OFS_WD-1:0]   ofs_q, ofs_d;
  logic [CNT_WD-1:0]   out_q, out_d;
  logic                err_q, err_d;
  logic                done_q, done_d;
  logic                done_err_q, done_err_d;
  logic                live_q;   // 0 only in reset: gates the constant outputs

  logic                req_fire, b_fire;
  logic [8:0]          cur_beats, nb;
  logic                unused_src;

  assign unused_src = ^cmd_src_addr[ADDR_WD-1:OFS_WD];

  // Beats for the burst starting at addr: min(rem, MAX_BURST_LEN, page beats).
  // The page term only takes effect in the 4 KB split build.
  function automatic logic [8:0] calc_beats(input logic [REM_WD-1:0]  rem,
                                            input logic [ADDR_WD-1:0] addr);
    logic [8:0]  b;
    logic [12:0] pb;
    b  = (rem < REM_WD'(MAX_BURST_LEN)) ? rem[8:0] : 9'(MAX_BURST_LEN);
    pb = 13'(4096 >> OFS_WD) - 13'(addr[11:OFS_WD]);
    if (SPLIT_4K && ({4'b0, b} > pb)) b = pb[8:0];
    return b;
  endfunction

  assign req_fire  = valid_q & wr_req_ready;
  assign b_fire    = m_axi_bvalid & live_q & (out_q != '0);
  assign cur_beats = {1'b0, len_q} + 9'd1;

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    addr_d     = addr_q;
    len_d      = len_q;
    last_d     = last_q;
    valid_d    = valid_q;
    ofs_d      = ofs_q;
    out_d      = out_q;
    err_d      = err_q;
    done_d     = 1'b0;
    done_err_d = 1'b0;
    nb         = '0;

    if (req_fire && !b_fire)      out_d = out_q + CNT_WD'(1);
    else if (!req_fire && b_fire) out_d = out_q - CNT_WD'(1);
    if (b_fire && (m_axi_bresp != 2'b00)) err_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          ofs_d  = cmd_src_addr[OFS_WD-1:0];
          err_d  = 1'b0;
          addr_d = cmd_dst_addr;
          rem_d  = (REM_WD'(cmd_bytes) + REM_WD'(cmd_dst_addr[OFS_WD-1:0])
                    + REM_WD'(BYTES - 1)) >> OFS_WD;
          if (cmd_bytes == '0) begin
            state_d = S_WAIT;
          end else begin
            nb      = calc_beats(rem_d, cmd_dst_addr);
            len_d   = 8'(nb - 9'd1);
            last_d  = (REM_WD'(nb) == rem_d);
            valid_d = 1'b1;
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (req_fire) begin
          rem_d = rem_q - REM_WD'(cur_beats);
          if (last_q) begin
            valid_d = 1'b0;
            state_d = S_WAIT;
          end else begin
            // Only the first burst can be unaligned; realign before stepping.
            addr_d  = {addr_q[ADDR_WD-1:OFS_WD], {OFS_WD{1'b0}}}
                      + (ADDR_WD'(cur_beats) << OFS_WD);
            nb      = calc_beats(rem_d, addr_d);
            len_d   = 8'(nb - 9'd1);
            last_d  = (REM_WD'(nb) == rem_d);
            valid_d = (out_d != CNT_WD'(MAX_OUTSTANDING));
          end
        end else begin
          valid_d = (out_d != CNT_WD'(MAX_OUTSTANDING));
        end
      end
      S_WAIT: begin
        if (out_d == '0) begin
          done_d     = 1'b1;
          done_err_d = err_d;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      rem_q      <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      last_q     <= 1'b0;
      valid_q    <= 1'b0;
      ofs_q      <= '0;
      out_q      <= '0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      done_err_q <= 1'b0;
      live_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      last_q     <= last_d;
      valid_q    <= valid_d;
      ofs_q      <= ofs_d;
      out_q      <= out_d;
      err_q      <= err_d;
      done_q     <= done_d;
      done_err_q <= done_err_d;
      live_q     <= 1'b1;
    end
  end

  assign cmd_ready          = (state_q == S_IDLE);
  assign cmd_done           = done_q;
  assign cmd_err            = done_err_q;
  assign wr_req_valid       = valid_q;
  assign wr_req_addr        = addr_q;
  assign wr_req_len         = len_q;
  assign wr_req_last        = last_q;
  assign wr_req_data_offset = ofs_q;
  assign wr_req_burst       = live_q ? 2'b01 : 2'b00;
  assign wr_req_size        = live_q ? 3'(OFS_WD) : 3'd0;
  assign m_axi_bready       = live_q;

endmodule

// File: tb/tb_dmac_write_burst_gen.sv
module tb_dmac_write_burst_gen;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_dst_addr = '0, cmd_src_addr = '0, cmd_bytes = '0;
  logic        cmd_done, cmd_err;
  logic        wr_req_valid;
  logic        wr_req_ready = 1'b1;
  logic [31:0] wr_req_addr;
  logic [1:0]  wr_req_burst;
  logic [7:0]  wr_req_len;
  logic [1:0]  wr_req_data_offset;
  logic [2:0]  wr_req_size;
  logic        wr_req_last;
  logic        m_axi_bvalid = 1'b0;
  logic        m_axi_bready;
  logic [1:0]  m_axi_bresp = 2'b00;

  dmac_write_burst_gen #(
    .ADDR_WD(32), .DATA_WD(32), .LEN_WD(32), .MAX_BURST_LEN(16), .MAX_OUTSTANDING(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dst_addr(cmd_dst_addr), .cmd_src_addr(cmd_src_addr), .cmd_bytes(cmd_bytes),
    .cmd_done(cmd_done), .cmd_err(cmd_err),
    .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready),
    .wr_req_addr(wr_req_addr), .wr_req_burst(wr_req_burst), .wr_req_len(wr_req_len),
    .wr_req_data_offset(wr_req_data_offset), .wr_req_size(wr_req_size),
    .wr_req_last(wr_req_last),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_bresp(m_axi_bresp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [1:0]  ofs;
    logic        last;
  } req_t;

  req_t exp_req[$];
  logic exp_done[$];
  int   checks = 0;
  int   passes = 0;
  int   acc_cnt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic push_req(input logic [31:0] a, input logic [7:0] l,
                          input logic [1:0] o, input logic last);
    req_t r;
    r.addr = a; r.len = l; r.ofs = o; r.last = last;
    exp_req.push_back(r);
  endtask

  // Monitor: pops expectations whenever the DUT presents a handshake or done.
  always @(negedge clk) begin : mon
    req_t e;
    if (rst_n) begin
      if (wr_req_valid && wr_req_ready) begin
        acc_cnt++;
        if (exp_req.size() == 0) begin
          checks++;
          $display("FAIL unexpected_req: got addr %0h len %0d, expected none", wr_req_addr, wr_req_len);
        end else begin
          e = exp_req.pop_front();
          chk("req_addr", 64'(wr_req_addr), 64'(e.addr));
          chk("req_len", 64'(wr_req_len), 64'(e.len));
          chk("req_ofs", 64'(wr_req_data_offset), 64'(e.ofs));
          chk("req_last", 64'(wr_req_last), 64'(e.last));
        end
      end
      if (cmd_done) begin
        chk("done_ready", 64'(cmd_ready), 64'd1);
        if (exp_done.size() == 0) begin
          checks++;
          $display("FAIL unexpected_done: got done, expected none");
        end else begin
          chk("done_err", 64'(cmd_err), 64'(exp_done.pop_front()));
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [31:0] dst, input logic [31:0] src, input logic [31:0] nbytes);
    int k = 0;
    while (!cmd_ready && k < 100) begin tick(); k++; end
    if (!cmd_ready) chk("cmd_ready_timeout", 64'(cmd_ready), 64'd1);
    cmd_dst_addr = dst; cmd_src_addr = src; cmd_bytes = nbytes; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_acc(input int n);
    int k = 0;
    while (acc_cnt < n && k < 200) begin tick(); k++; end
    if (acc_cnt < n) chk("acc_timeout", 64'(acc_cnt), 64'(n));
  endtask

  task automatic send_b(input logic [1:0] resp);
    m_axi_bvalid = 1'b1; m_axi_bresp = resp;
    tick();
    m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
  endtask

  task automatic wait_done();
    int k = 0;
    while (exp_done.size() != 0 && k < 300) begin tick(); k++; end
    chk("done_seen", 64'(exp_done.size()), 64'd0);
  endtask

  initial begin
    // Reset values
    #2;
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("rst_req_valid", 64'(wr_req_valid), 64'd0);
    chk("rst_done", 64'(cmd_done), 64'd0);
    chk("rst_bready", 64'(m_axi_bready), 64'd0);
    chk("rst_burst", 64'(wr_req_burst), 64'd0);
    tick(2);
    rst_n = 1'b1;
    tick(2);
    chk("bready", 64'(m_axi_bready), 64'd1);
    chk("burst_incr", 64'(wr_req_burst), 64'd1);
    chk("size", 64'(wr_req_size), 64'd2);

    // Aligned single burst
    acc_cnt = 0;
    push_req(32'h1000, 8'd15, 2'd0, 1'b1); exp_done.push_back(1'b0);
    send_cmd(32'h1000, 32'h0, 32'd64);
    wait_acc(1); send_b(2'b00); wait_done();

    // Crossing a 4 KB page
    acc_cnt = 0;
`ifdef DMAC_WR_4K_SPLIT_EN
    push_req(32'h0FF8, 8'd1, 2'd0, 1'b0);
    push_req(32'h1000, 8'd5, 2'd0, 1'b1);
    exp_done.push_back(1'b0);
    send_cmd(32'h0FF8, 32'h0, 32'd32);
    wait_acc(2); send_b(2'b00); send_b(2'b00); wait_done();
`else
    push_req(32'h0FF8, 8'd7, 2'd0, 1'b1);
    exp_done.push_back(1'b0);
    send_cmd(32'h0FF8, 32'h0, 32'd32);
    wait_acc(1); send_b(2'b00); wait_done();
`endif

    // Unaligned dst with source offset
    acc_cnt = 0;
    push_req(32'h1002, 8'd2, 2'd3, 1'b1); exp_done.push_back(1'b0);
    send_cmd(32'h1002, 32'h3, 32'd8);
    wait_acc(1); send_b(2'b00); wait_done();

    // Outstanding limit: 16 bursts, responses held back
    acc_cnt = 0;
    for (int i = 0; i < 16; i++) push_req(32'h2000 + 32'(i * 64), 8'd15, 2'd0, i == 15);
    exp_done.push_back(1'b0);
    send_cmd(32'h2000, 32'h0, 32'd1024);
    wait_acc(8); tick(10);
    chk("stall_count", 64'(acc_cnt), 64'd8);
    chk("stall_valid", 64'(wr_req_valid), 64'd0);
    send_b(2'b00);
    wait_acc(9); tick(5);
    chk("one_b_count", 64'(acc_cnt), 64'd9);
    for (int i = 1; i < 16; i++) begin
      wait_acc(i + 1);
      send_b(2'b00);
    end
    wait_done();

    // Error response, then a clean command clears it
    acc_cnt = 0;
    push_req(32'h3000, 8'd15, 2'd0, 1'b0);
    push_req(32'h3040, 8'd15, 2'd0, 1'b1);
    exp_done.push_back(1'b1);
    send_cmd(32'h3000, 32'h0, 32'd128);
    wait_acc(2); send_b(2'b00); send_b(2'b10); wait_done();
    acc_cnt = 0;
    push_req(32'h4000, 8'd0, 2'd0, 1'b1); exp_done.push_back(1'b0);
    send_cmd(32'h4000, 32'h0, 32'd4);
    wait_acc(1); send_b(2'b00); wait_done();

    // Reset while issuing
    wr_req_ready = 1'b0;
    send_cmd(32'h5000, 32'h1, 32'd1024);
    tick(3);
    chk("pre_rst_valid", 64'(wr_req_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", 64'(cmd_ready), 64'd1);
    chk("mid_rst_valid", 64'(wr_req_valid), 64'd0);
    chk("mid_rst_addr", 64'(wr_req_addr), 64'd0);
    chk("mid_rst_len", 64'(wr_req_len), 64'd0);
    chk("mid_rst_ofs", 64'(wr_req_data_offset), 64'd0);
    chk("mid_rst_bready", 64'(m_axi_bready), 64'd0);
    exp_req.delete(); exp_done.delete();
    tick(2);
    rst_n = 1'b1;
    wr_req_ready = 1'b1;
    tick(2);
    acc_cnt = 0;
    push_req(32'h6000, 8'd15, 2'd0, 1'b1); exp_done.push_back(1'b0);
    send_cmd(32'h6000, 32'h0, 32'd64);
    wait_acc(1); send_b(2'b00); wait_done();

    tick(3);
    chk("leftover_reqs", 64'(exp_req.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
